// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder.
// Holds the fetch state encodings, the default bus widths and the
// chip-enable polarity used by the PC generator handshake.
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_BUS  = 32;
  localparam int INST_BUS       = 32;
  localparam int MEM_BYTE_BUS   = 8;

  localparam logic CHIP_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_BUSY = 2'b01,
    IF_DONE = 2'b10
  } if_state_e;

  // A fetch address is usable only when it sits on a 4-byte boundary.
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder.
// Takes a {pc_i, ce_i} request, reads the instruction one byte per memory
// beat, assembles the bytes little-endian and hands the word to IF/ID with a
// one-cycle inst_valid_o. stall_o freezes the PC generator while busy.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_WIDTH     = INST_ADDR_BUS,
  parameter int INST_WIDTH     = INST_BUS,
  parameter int MEM_DATA_WIDTH = MEM_BYTE_BUS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  input  logic                      ce_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [INST_WIDTH-1:0]     inst_o,
  output logic [ADDR_WIDTH-1:0]     inst_pc_o,
  output logic                      inst_valid_o,
  output logic                      misalign_o,
  output logic                      mem_req_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  input  logic                      mem_ack_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int BEATS  = INST_WIDTH / MEM_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1'b1);

  if_state_e                 state_r;
  logic [BEAT_W-1:0]         beat_r;
  logic [ADDR_WIDTH-1:0]     base_r;
  logic [MEM_DATA_WIDTH-1:0] lane_r [BEATS];

  logic [BEAT_W-1:0]         beat_next_s;
  logic [ADDR_WIDTH-1:0]     next_addr_s;
  logic [INST_WIDTH-1:0]     inst_next_s;

  // Busy whenever a fetch is in flight or its result is being delivered.
  assign stall_o = (state_r != IF_IDLE);

  // Address of the following beat; wraps naturally at the top of the address space.
  always_comb begin
    beat_next_s = beat_r + BEAT_ONE;
    next_addr_s = base_r + ADDR_WIDTH'(beat_next_s);
  end

  // Word as it will look once the byte arriving now lands in its lane.
  always_comb begin
    inst_next_s = {INST_WIDTH{1'b0}};
    for (int i = 0; i < BEATS; i++) begin
      inst_next_s[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] =
        (beat_r == BEAT_W'(i)) ? mem_rdata_i : lane_r[i];
    end
  end

  // Fetch sequencer with registered handshake and delivery outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IF_IDLE;
      beat_r       <= {BEAT_W{1'b0}};
      base_r       <= {ADDR_WIDTH{1'b0}};
      for (int i = 0; i < BEATS; i++) begin
        lane_r[i] <= {MEM_DATA_WIDTH{1'b0}};
      end
      inst_o       <= {INST_WIDTH{1'b0}};
      inst_pc_o    <= {ADDR_WIDTH{1'b0}};
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= {ADDR_WIDTH{1'b0}};
    end else begin
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      case (state_r)
        IF_IDLE: begin
          mem_req_o  <= 1'b0;
          mem_addr_o <= {ADDR_WIDTH{1'b0}};
          // A redirect in the same cycle wins over a new request.
          if (!flush_i && (ce_i == CHIP_ENABLE)) begin
            if (word_aligned(pc_i[1:0])) begin
              state_r    <= IF_BUSY;
              base_r     <= pc_i;
              beat_r     <= {BEAT_W{1'b0}};
              mem_req_o  <= 1'b1;
              mem_addr_o <= pc_i;
            end else begin
              misalign_o <= 1'b1;
            end
          end
        end
        IF_BUSY: begin
          if (flush_i) begin
            // Abort: any byte acknowledged this cycle is discarded.
            state_r    <= IF_IDLE;
            beat_r     <= {BEAT_W{1'b0}};
            mem_req_o  <= 1'b0;
            mem_addr_o <= {ADDR_WIDTH{1'b0}};
          end else if (mem_ack_i) begin
            lane_r[beat_r] <= mem_rdata_i;
            if (beat_r == LAST_BEAT) begin
              state_r      <= IF_DONE;
              beat_r       <= {BEAT_W{1'b0}};
              mem_req_o    <= 1'b0;
              mem_addr_o   <= {ADDR_WIDTH{1'b0}};
              inst_valid_o <= 1'b1;
              inst_o       <= inst_next_s;
              inst_pc_o    <= base_r;
            end else begin
              beat_r     <= beat_next_s;
              mem_addr_o <= next_addr_s;
            end
          end else begin
            // Waiting on memory: keep the request and address steady.
            mem_req_o <= 1'b1;
          end
        end
        IF_DONE: begin
          // The delivery pulse is already out; return to idle either way.
          state_r    <= IF_IDLE;
          mem_req_o  <= 1'b0;
          mem_addr_o <= {ADDR_WIDTH{1'b0}};
        end
        default: begin
          state_r    <= IF_IDLE;
          beat_r     <= {BEAT_W{1'b0}};
          mem_req_o  <= 1'b0;
          mem_addr_o <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp: directed fetches against a byte memory,
// a transaction-level model checked every cycle, and literal expectations.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = 8'h0;

  always #5 clk = ~clk;

  inst_fetch_resp dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .stall_o(stall_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory ----------------
  logic [7:0]  mem [logic [31:0]];
  int          waits = 0;
  int          wcnt = 0;
  logic [31:0] ack_addrs [$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory responder: acks after 'waits' idle cycles per beat.
  initial forever begin
    @(negedge clk);
    if (rst && mem_req_o) begin
      if (wcnt < waits) begin
        wcnt++;
        mem_ack_i = 1'b0;
      end else begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_byte(mem_addr_o);
        ack_addrs.push_back(mem_addr_o);
        wcnt = 0;
      end
    end else begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  // ---------------- model ----------------
  logic        s_rst, s_ce, s_flush, s_ack;
  logic [31:0] s_pc;
  logic [7:0]  s_rdata;
  bit          s_tick = 0;

  // Snapshot what the DUT samples on each rising edge.
  initial forever begin
    @(posedge clk);
    s_rst = rst; s_ce = ce_i; s_flush = flush_i; s_ack = mem_ack_i;
    s_pc = pc_i; s_rdata = mem_rdata_i; s_tick = 1;
  end

  bit          m_busy = 0, m_done = 0;
  int          m_got = 0;
  logic [31:0] m_base = 32'h0;
  logic [7:0]  m_bytes [4];
  logic        e_valid = 1'b0, e_mis = 1'b0;
  logic [31:0] e_inst = 32'h0, e_pc = 32'h0;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_got = 0; e_valid = 1'b0; e_mis = 1'b0;
  endtask

  task automatic model_step();
    bit was_done;
    was_done = m_done;
    m_done = 0; e_valid = 1'b0; e_mis = 1'b0;
    if (m_busy) begin
      if (s_flush) m_busy = 0;
      else if (s_ack) begin
        m_bytes[m_got] = s_rdata;
        m_got++;
        if (m_got == 4) begin
          m_busy = 0; m_done = 1; e_valid = 1'b1;
          e_inst = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          e_pc = m_base;
        end
      end
    end else if (!was_done && !s_flush && s_ce) begin
      if (s_pc[1:0] == 2'b00) begin
        m_busy = 1; m_base = s_pc; m_got = 0;
      end else e_mis = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      model_reset();
      s_tick = 0;
      chk("reset_outs", {stall_o, mem_req_o, inst_valid_o, misalign_o,
                         |mem_addr_o, |inst_o, |inst_pc_o}, 64'd0);
    end else begin
      if (s_tick) begin
        if (!s_rst) model_reset();
        else model_step();
      end
      s_tick = 0;
      chk("stall", stall_o, m_busy | m_done);
      chk("mem_req", mem_req_o, m_busy);
      if (m_busy) chk("mem_addr", mem_addr_o, m_base + 32'(m_got));
      chk("inst_valid", inst_valid_o, e_valid);
      chk("misalign", misalign_o, e_mis);
      if (e_valid) begin
        chk("inst", inst_o, e_inst);
        chk("inst_pc", inst_pc_o, e_pc);
      end
    end
  end

  // ---------------- directed ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, output int lat, output logic [31:0] inst,
                       output logic [31:0] ipc, output int stall_hi);
    bit got;
    got = 0; lat = 0; stall_hi = 0; inst = 32'h0; ipc = 32'h0;
    pc_i = pc; ce_i = 1'b1;
    tick();
    ce_i = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (inst_valid_o) begin
        got = 1; lat = c; inst = inst_o; ipc = inst_pc_o;
      end else begin
        if (stall_o) stall_hi++;
        tick();
      end
    end
    if (!got) chk("fetch_timeout", 64'd0, 64'd1);
    tick();
  endtask

  int          lat, shi, cnt;
  logic [31:0] inst, ipc;

  initial begin
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    mem[32'h200] = 8'h78; mem[32'h201] = 8'h56; mem[32'h202] = 8'h34; mem[32'h203] = 8'h12;

    // 1: reset held with a request pending
    pc_i = 32'h100; ce_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req_o || stall_o) cnt++;
    end
    chk("t1_req_in_reset", cnt, 0);
    ce_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 2: zero-wait fetch
    ack_addrs.delete();
    waits = 0;
    fetch(32'h100, lat, inst, ipc, shi);
    chk("t2_latency", lat, 5);
    chk("t2_inst", inst, 32'h0000_0013);
    chk("t2_pc", ipc, 32'h100);
    chk("t2_nacks", ack_addrs.size(), 4);
    for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
      chk("t2_addr", ack_addrs[i], 32'h100 + 32'(i));

    // 3: two wait cycles before each ack
    waits = 2;
    fetch(32'h100, lat, inst, ipc, shi);
    chk("t3_latency", lat, 13);
    chk("t3_stall_cycles", shi, 12);
    chk("t3_inst", inst, 32'h0000_0013);
    waits = 0;

    // 4: misaligned request
    pc_i = 32'h102; ce_i = 1'b1;
    tick();
    ce_i = 1'b0;
    chk("t4_misalign", misalign_o, 1'b1);
    chk("t4_no_req", mem_req_o, 1'b0);
    chk("t4_no_stall", stall_o, 1'b0);
    tick();
    chk("t4_pulse_end", misalign_o, 1'b0);

    // 5: flush after the second ack, then a clean fetch
    pc_i = 32'h100; ce_i = 1'b1;
    tick();
    ce_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5_req_dropped", mem_req_o, 1'b0);
    chk("t5_idle", stall_o, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid_o) cnt++;
      tick();
    end
    chk("t5_no_valid", cnt, 0);
    fetch(32'h200, lat, inst, ipc, shi);
    chk("t5_inst", inst, 32'h1234_5678);
    chk("t5_pc", ipc, 32'h200);
    chk("t5_latency", lat, 5);

    // flush beats a simultaneous request in idle
    pc_i = 32'h300; ce_i = 1'b1; flush_i = 1'b1;
    tick();
    ce_i = 1'b0; flush_i = 1'b0;
    chk("flush_prio_req", mem_req_o, 1'b0);
    chk("flush_prio_stall", stall_o, 1'b0);

    // 6: top-of-memory wrap, full fetch
    ack_addrs.delete();
    fetch(32'hFFFF_FFFC, lat, inst, ipc, shi);
    chk("t6_inst", inst, 32'h5A5B_5859);
    chk("t6_pc", ipc, 32'hFFFF_FFFC);
    chk("t6_last_addr", (ack_addrs.size() == 4) ? ack_addrs[3] : 32'h0, 32'hFFFF_FFFF);

    // 6: async reset at beat 2
    ack_addrs.delete();
    pc_i = 32'hFFFF_FFFC; ce_i = 1'b1;
    tick();
    ce_i = 1'b0;
    tick();
    tick();
    chk("t6_beat2_addr", mem_addr_o, 32'hFFFF_FFFE);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_req", mem_req_o, 1'b0);
    chk("t6_async_stall", stall_o, 1'b0);
    chk("t6_async_addr", mem_addr_o, 32'h0);
    chk("t6_async_valid", inst_valid_o, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inst_valid_o || mem_req_o) cnt++;
    end
    chk("t6_no_resume", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
